// File: rtl/clk_div_pkg.sv
// Shared constants and types for the clk_div_gen divider bank.
package clk_div_pkg;

  // Smallest divisor that still yields one high and one low cycle.
  localparam int DIV_MIN   = 2;
  localparam int DEF_CNT_W = 16;
  // 16 MHz / 488 ~= 32.768 kHz
  localparam int DEF_DIV   = 488;

  // Channel control: idle (stopped, output low) or running a period.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_fsm_t;

  // Per-channel state view; fields are DEF_CNT_W wide (wider divisors are
  // truncated in this debug view only).
  typedef struct packed {
    logic [DEF_CNT_W-1:0] active;
    logic [DEF_CNT_W-1:0] shadow;
    logic                 pending;
    logic [DEF_CNT_W-1:0] count;
  } ch_state_t;

  // Divisors below DIV_MIN are raised to DIV_MIN.
  function automatic int clamp_div(input int d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: active/shadow divisor, period counter, registered
// clk_out and tick. Optional macro CLK_DIV_ODD_DUTY50_EN stretches the high
// phase of odd divisors by half a clk cycle using a falling-edge flop.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_div,
  output logic             o_clk,
  output logic             o_tick,
  output logic             o_pending,
  output logic             o_run,
  output ch_state_t        o_state
);

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(clamp_div(DEFAULT_DIV));
  localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(DIV_MIN);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  ch_fsm_t          r_st;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_shadow;
  logic             r_pend;
  logic             r_clk;
  logic             r_tick;

  logic [CNT_W-1:0] w_wr_div;
  logic [CNT_W-1:0] w_half;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_last;

  assign w_wr_div  = (i_div < MIN_DIV) ? MIN_DIV : i_div;
  assign w_half    = r_div >> 1;
  assign w_cnt_nxt = r_cnt + ONE;
  assign w_last    = (r_cnt == r_div - ONE);

  // Period FSM: start on en, wrap at D-1 (loading a pending shadow), stop at
  // the end of a period once en has dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_st     <= ST_IDLE;
      r_cnt    <= '0;
      r_div    <= RST_DIV;
      r_shadow <= RST_DIV;
      r_pend   <= 1'b0;
      r_clk    <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      // A write never coincides with a pending load: cfg_ready blocks it.
      if (i_wr) begin
        r_shadow <= w_wr_div;
        r_pend   <= 1'b1;
      end
      case (r_st)
        ST_IDLE: begin
          if (r_pend) begin
            r_div  <= r_shadow;
            r_pend <= 1'b0;
          end
          if (i_en) begin
            r_st   <= ST_RUN;
            r_cnt  <= '0;
            r_clk  <= 1'b1;
            r_tick <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_last) begin
            if (r_pend) begin
              r_div  <= r_shadow;
              r_pend <= 1'b0;
            end
            r_cnt <= '0;
            if (i_en) begin
              r_clk  <= 1'b1;
              r_tick <= 1'b1;
            end else begin
              r_st  <= ST_IDLE;
              r_clk <= 1'b0;
            end
          end else begin
            r_cnt <= w_cnt_nxt;
            r_clk <= (w_cnt_nxt < w_half);
          end
        end
        default: r_st <= ST_IDLE;
      endcase
    end
  end

`ifdef CLK_DIV_ODD_DUTY50_EN
  logic r_clk_neg;

  // Half-cycle delayed copy of the high phase, only for odd divisors.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) r_clk_neg <= 1'b0;
    else       r_clk_neg <= r_clk & r_div[0];
  end

  assign o_clk = r_clk | r_clk_neg;
`else
  assign o_clk = r_clk;
`endif

  assign o_tick    = r_tick;
  assign o_pending = r_pend;
  assign o_run     = (r_st == ST_RUN);

  // Debug view of the channel state.
  always_comb begin
    o_state         = '0;
    o_state.active  = DEF_CNT_W'(r_div);
    o_state.shadow  = DEF_CNT_W'(r_shadow);
    o_state.pending = r_pend;
    o_state.count   = DEF_CNT_W'(r_cnt);
  end

endmodule

// File: rtl/clk_div_gen.sv
// Bank of NUM_CH independent clock dividers sharing one divisor-write port.
// Handshake: a write transfers on a rising clk edge where cfg_valid and
// cfg_ready are both high; cfg_ready is low while the addressed channel
// still holds an unloaded shadow divisor. Writes to cfg_ch >= NUM_CH are
// accepted and dropped. Optional macro: CLK_DIV_ODD_DUTY50_EN.
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int  NUM_CH      = 2,
  parameter int  CNT_W       = DEF_CNT_W,
  parameter int  DEFAULT_DIV = DEF_DIV,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int ST_W        = $bits(ch_state_t)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_CH-1:0]      en,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [CH_W-1:0]        cfg_ch,
  input  logic [CNT_W-1:0]       cfg_div,
  output logic [NUM_CH-1:0]      clk_out,
  output logic [NUM_CH-1:0]      tick,
  output logic [NUM_CH-1:0]      dbg_run,
  output logic [NUM_CH*ST_W-1:0] dbg_state
);

  logic [NUM_CH-1:0]      w_pend;
  logic [NUM_CH-1:0]      w_wr;
  logic [(1<<CH_W)-1:0]   w_pend_ext;

  // Pad pending flags so an out-of-range cfg_ch reads as not pending.
  always_comb begin
    w_pend_ext               = '0;
    w_pend_ext[NUM_CH-1:0]   = w_pend;
  end

  assign cfg_ready = ~w_pend_ext[cfg_ch];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_wr[g] = cfg_valid & cfg_ready & (cfg_ch == CH_W'(g));

    clk_div_ch #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .i_en      (en[g]),
      .i_wr      (w_wr[g]),
      .i_div     (cfg_div),
      .o_clk     (clk_out[g]),
      .o_tick    (tick[g]),
      .o_pending (w_pend[g]),
      .o_run     (dbg_run[g]),
      .o_state   (dbg_state[g*ST_W +: ST_W])
    );
  end

endmodule
